stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter ADDR_W, default 8, spill-RAM address width; RAM holds 2^ADDR_W words; max depth MAXD = 2^ADDR_W + 1 (RAM plus TOS register).
REQ-003 Port clk  input  1  clock, all state updates on rising edge.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port op_valid  input  1  operation request.
REQ-006 Port op_ready  output  1  unit can accept an operation this cycle.
REQ-007 Port op_code  input  3  0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 REPLACE, 6-7 illegal.
REQ-008 Port op_data  input  WIDTH  operand for PUSH/REPLACE.
REQ-009 Port done  output  1  one-cycle completion pulse.
REQ-010 Port err  output  1  qualifies done: operation rejected, no state change.
REQ-011 Port result  output  WIDTH  popped value, valid with done for POP; else 0.
REQ-012 Port tos  output  WIDTH  current top-of-stack register.
REQ-013 Port depth  output  ADDR_W+2  current entry count, 0..MAXD.
REQ-014 Port empty / full  output  1 each  depth==0 / depth==MAXD.
REQ-015 Port ram_addr  output  ADDR_W  spill-RAM address.
REQ-016 Port ram_wdata  output  WIDTH  spill-RAM write data.
REQ-017 Port ram_wen  output  1  spill-RAM write enable.
REQ-018 Port ram_rdata  input  WIDTH  spill-RAM read data, valid one cycle after address presented (synchronous read).

Function
REQ-019 Storage: TOS in register; entries below TOS in RAM[0..sp-1]; sp = depth-1 when depth>=1, else 0.
REQ-020 States IDLE, POP_WAIT, SWAP_WAIT; op_ready = (state==IDLE); operation accepted when op_valid & op_ready.
REQ-021 Single-cycle ops (NOP, PUSH, DUP, REPLACE, POP at depth 1, any error): state updated and done pulsed in cycle following acceptance.
REQ-022 PUSH: if depth>=1, ram_wen=1, ram_addr=sp, ram_wdata=TOS in acceptance cycle; TOS<=op_data; depth+1.
REQ-023 DUP: as PUSH with op_data replaced by current TOS; requires depth>=1.
REQ-024 REPLACE: TOS<=op_data; depth unchanged; requires depth>=1.
REQ-025 POP depth 1: result=TOS, TOS<=0, depth 0.
REQ-026 POP depth>=2: acceptance cycle drives ram_addr=sp-1 (read); enter POP_WAIT; in POP_WAIT TOS<=ram_rdata, depth-1, result=old TOS; done pulses cycle after POP_WAIT; total 2 cycles busy.
REQ-027 SWAP (depth>=2): acceptance cycle reads ram_addr=sp-1; SWAP_WAIT cycle writes ram[sp-1]=TOS (ram_wen=1) and TOS<=ram_rdata; done follows; depth unchanged.
REQ-028 Errors (done=1, err=1, no state or RAM change, ram_wen stays 0): PUSH/DUP at full; POP/DUP/REPLACE at empty; SWAP at depth<2; op_code 6-7.
REQ-029 NOP: done=1, err=0, no change.
REQ-030 ram_wen asserted only in cycles specified in REQ-022/023/027; never in error or reset cycles.
REQ-031 result is 0 whenever done=0 or op is not a successful POP.
REQ-032 Depth wrap forbidden: depth never exceeds MAXD nor drops below 0.

Reset
REQ-033 While reset high: state IDLE, TOS 0, depth 0, sp 0, done 0, err 0, result 0, ram_wen 0, ram_addr 0, ram_wdata 0; op_ready 1 first cycle after reset deasserts.
REQ-034 Reset during POP_WAIT/SWAP_WAIT aborts the operation: no done pulse, no RAM write, stack empty afterward; RAM contents not cleared (unreachable).

Verification
REQ-035 Reset, then POP -> done=1, err=1, depth=0, ram_wen never high.
REQ-036 PUSH 0x1111, 0x2222, 0x3333 -> depth=3, tos=0x3333, RAM[0]=0x1111, RAM[1]=0x2222, each done one cycle after accept.
REQ-037 From REQ-036 state, SWAP then POP -> SWAP busy 2 cycles, RAM[1]=0x3333; POP result=0x2222, tos=0x3333, depth=2.
REQ-038 ADDR_W=2: five PUSHes -> full=1, depth=5; sixth PUSH -> err=1, depth 5, tos unchanged.
REQ-039 PUSH 0xAAAA, PUSH 0xBBBB, POP with reset asserted in POP_WAIT -> no done, depth=0, tos=0, op_ready=1 after release.
REQ-040 Depth 1, DUP then REPLACE 0x5A5A then op_code 7 -> depth 2, RAM[0]=old tos, tos=0x5A5A; op 7 gives err=1, no change.

Source files
------------

// File: rtl/stack_unit.sv
// Hardware stack: top-of-stack held in a register, deeper entries spilled to
// an external synchronous-read RAM. POP and SWAP at depth>=2 take one extra wait cycle.
module stack_unit #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [2:0]          op_code,
  input  logic [WIDTH-1:0]    op_data,
  output logic                done,
  output logic                err,
  output logic [WIDTH-1:0]    result,
  output logic [WIDTH-1:0]    tos,
  output logic [ADDR_W+1:0]   depth,
  output logic                empty,
  output logic                full,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [WIDTH-1:0]    ram_wdata,
  output logic                ram_wen,
  input  logic [WIDTH-1:0]    ram_rdata
);

  localparam int unsigned DW  = ADDR_W + 2;
  localparam int unsigned SPW = ADDR_W + 1;
  localparam logic [DW-1:0] MAXD = DW'((1 << ADDR_W) + 1);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_DUP     = 3'd3;
  localparam logic [2:0] OP_SWAP    = 3'd4;
  localparam logic [2:0] OP_REPLACE = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_POP_WAIT  = 2'd1,
    ST_SWAP_WAIT = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   tos_q;
  logic [DW-1:0]      depth_q;
  logic               done_q;
  logic               err_q;
  logic [WIDTH-1:0]   result_q;

  logic               accept;
  logic               is_empty;
  logic               is_full;
  logic               two_plus;
  logic               op_err;
  logic [SPW-1:0]     sp;
  logic [SPW-1:0]     sp_m1;

  // Spill pointer: number of entries held in RAM below the TOS register.
  always_comb begin
    sp    = (depth_q == '0) ? '0 : SPW'(depth_q - DW'(1));
    sp_m1 = SPW'(sp - SPW'(1));
  end

  // Operation legality against the current depth.
  always_comb begin
    is_empty = (depth_q == '0);
    is_full  = (depth_q == MAXD);
    two_plus = (depth_q >= DW'(2));
    accept   = op_valid && (state_q == ST_IDLE) && !reset;
    op_err   = 1'b0;
    case (op_code)
      OP_NOP:     op_err = 1'b0;
      OP_PUSH:    op_err = is_full;
      OP_POP:     op_err = is_empty;
      OP_DUP:     op_err = is_full || is_empty;
      OP_SWAP:    op_err = !two_plus;
      OP_REPLACE: op_err = is_empty;
      default:    op_err = 1'b1;
    endcase
  end

  // RAM port is driven combinationally in the acceptance / wait cycle.
  always_comb begin
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!reset) begin
      if (accept && !op_err) begin
        case (op_code)
          OP_PUSH: begin
            if (!is_empty) begin
              ram_wen   = 1'b1;
              ram_addr  = ADDR_W'(sp);
              ram_wdata = tos_q;
            end
          end
          OP_DUP: begin
            ram_wen   = 1'b1;
            ram_addr  = ADDR_W'(sp);
            ram_wdata = tos_q;
          end
          OP_POP: begin
            if (two_plus) ram_addr = ADDR_W'(sp_m1);
          end
          OP_SWAP: ram_addr = ADDR_W'(sp_m1);
          default: ;
        endcase
      end
      if (state_q == ST_POP_WAIT) begin
        ram_addr = ADDR_W'(sp_m1);
      end
      if (state_q == ST_SWAP_WAIT) begin
        ram_wen   = 1'b1;
        ram_addr  = ADDR_W'(sp_m1);
        ram_wdata = tos_q;
      end
    end
  end

  // Control FSM and stack state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tos_q    <= '0;
      depth_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (op_err) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              done_q <= 1'b1;
              case (op_code)
                OP_PUSH: begin
                  tos_q   <= op_data;
                  depth_q <= depth_q + DW'(1);
                end
                OP_DUP: depth_q <= depth_q + DW'(1);
                OP_REPLACE: tos_q <= op_data;
                OP_POP: begin
                  if (two_plus) begin
                    done_q  <= 1'b0;
                    state_q <= ST_POP_WAIT;
                  end else begin
                    result_q <= tos_q;
                    tos_q    <= '0;
                    depth_q  <= '0;
                  end
                end
                OP_SWAP: begin
                  done_q  <= 1'b0;
                  state_q <= ST_SWAP_WAIT;
                end
                default: ;
              endcase
            end
          end
        end
        ST_POP_WAIT: begin
          tos_q    <= ram_rdata;
          depth_q  <= depth_q - DW'(1);
          result_q <= tos_q;
          done_q   <= 1'b1;
          state_q  <= ST_IDLE;
        end
        ST_SWAP_WAIT: begin
          tos_q   <= ram_rdata;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign op_ready = (state_q == ST_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign result   = result_q;
  assign tos      = tos_q;
  assign depth    = depth_q;
  assign empty    = (depth_q == '0);
  assign full     = (depth_q == MAXD);

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit with a small spill RAM (ADDR_W=2, max depth 5).
module tb_stack_unit;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_code;
  logic [WIDTH-1:0]  op_data;
  logic              done;
  logic              err;
  logic [WIDTH-1:0]  result;
  logic [WIDTH-1:0]  tos;
  logic [ADDR_W+1:0] depth;
  logic              empty;
  logic              full;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_wdata;
  logic              ram_wen;
  logic [WIDTH-1:0]  ram_rdata;

  logic [WIDTH-1:0]  mem [0:3];
  int                wen_count = 0;

  int n_chk  = 0;
  int n_pass = 0;

  logic              acc_wen;
  logic [ADDR_W-1:0] acc_addr;
  logic [WIDTH-1:0]  acc_wdata;
  int                lat;
  int                wen_before;

  stack_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_data(op_data), .done(done), .err(err),
    .result(result), .tos(tos), .depth(depth), .empty(empty), .full(full),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read spill RAM model
  always @(posedge clk) begin
    if (ram_wen) begin
      mem[ram_addr] <= ram_wdata;
      wen_count     <= wen_count + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one op at a negedge, capture acceptance-cycle RAM port, wait for done.
  task automatic do_op(input logic [2:0] code, input logic [WIDTH-1:0] data);
    @(negedge clk);
    check("ready_before_op", 32'(op_ready), 32'd1);
    op_valid = 1'b1;
    op_code  = code;
    op_data  = data;
    #1;
    acc_wen   = ram_wen;
    acc_addr  = ram_addr;
    acc_wdata = ram_wdata;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    op_code  = 3'd0;
    op_data  = '0;
    lat = 1;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    reset    = 1'b1;
    op_valid = 1'b1;
    op_code  = 3'd1;
    op_data  = 16'hFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_tos", 32'(tos), 32'd0);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_ram_wen", 32'(ram_wen), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    op_valid = 1'b0;
    op_code  = 3'd0;
    op_data  = '0;
    reset    = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(op_ready), 32'd1);
    check("idle_no_done", 32'(done), 32'd0);

    // POP on empty stack
    do_op(3'd2, 16'h0);
    check("pop_empty_lat", 32'(lat), 32'd1);
    check("pop_empty_err", 32'(err), 32'd1);
    check("pop_empty_depth", 32'(depth), 32'd0);
    check("pop_empty_result", 32'(result), 32'd0);
    check("pop_empty_wen", 32'(wen_count), 32'd0);

    // Three pushes
    do_op(3'd1, 16'h1111);
    check("push1_lat", 32'(lat), 32'd1);
    check("push1_wen", 32'(acc_wen), 32'd0);
    check("push1_tos", 32'(tos), 32'h1111);
    check("push1_result", 32'(result), 32'd0);
    do_op(3'd1, 16'h2222);
    check("push2_lat", 32'(lat), 32'd1);
    check("push2_wen", 32'(acc_wen), 32'd1);
    check("push2_addr", 32'(acc_addr), 32'd0);
    check("push2_wdata", 32'(acc_wdata), 32'h1111);
    do_op(3'd1, 16'h3333);
    check("push3_lat", 32'(lat), 32'd1);
    check("push3_addr", 32'(acc_addr), 32'd1);
    check("push3_wdata", 32'(acc_wdata), 32'h2222);
    check("push3_depth", 32'(depth), 32'd3);
    check("push3_tos", 32'(tos), 32'h3333);
    check("push3_err", 32'(err), 32'd0);
    check("mem0", 32'(mem[0]), 32'h1111);
    check("mem1", 32'(mem[1]), 32'h2222);

    // SWAP then POP
    do_op(3'd4, 16'h0);
    check("swap_lat", 32'(lat), 32'd2);
    check("swap_rd_addr", 32'(acc_addr), 32'd1);
    check("swap_acc_wen", 32'(acc_wen), 32'd0);
    check("swap_err", 32'(err), 32'd0);
    check("swap_tos", 32'(tos), 32'h2222);
    check("swap_depth", 32'(depth), 32'd3);
    check("swap_mem1", 32'(mem[1]), 32'h3333);
    do_op(3'd2, 16'h0);
    check("pop_lat", 32'(lat), 32'd2);
    check("pop_rd_addr", 32'(acc_addr), 32'd1);
    check("pop_result", 32'(result), 32'h2222);
    check("pop_tos", 32'(tos), 32'h3333);
    check("pop_depth", 32'(depth), 32'd2);
    @(negedge clk);
    check("pop_result_clears", 32'(result), 32'd0);

    // Fill to MAXD=5, then overflow attempts
    do_op(3'd1, 16'h4444);
    do_op(3'd1, 16'h5555);
    do_op(3'd1, 16'h6666);
    check("fill_addr", 32'(acc_addr), 32'd3);
    check("fill_wdata", 32'(acc_wdata), 32'h5555);
    check("fill_depth", 32'(depth), 32'd5);
    check("fill_full", 32'(full), 32'd1);
    wen_before = wen_count;
    do_op(3'd1, 16'h7777);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_wen", 32'(acc_wen), 32'd0);
    check("ovf_depth", 32'(depth), 32'd5);
    check("ovf_tos", 32'(tos), 32'h6666);
    do_op(3'd3, 16'h0);
    check("dup_full_err", 32'(err), 32'd1);
    check("ovf_no_write", 32'(wen_count), 32'(wen_before));
    do_op(3'd2, 16'h0);
    check("pop_full_result", 32'(result), 32'h6666);
    check("pop_full_tos", 32'(tos), 32'h5555);
    check("pop_full_depth", 32'(depth), 32'd4);

    // Reset asserted during POP_WAIT aborts the pop
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    do_op(3'd1, 16'hAAAA);
    do_op(3'd1, 16'hBBBB);
    wen_before = wen_count;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 3'd2;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    op_code  = 3'd0;
    check("abort_in_wait", 32'(op_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_done_rst", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_done_after", 32'(done), 32'd0);
    check("abort_depth", 32'(depth), 32'd0);
    check("abort_tos", 32'(tos), 32'd0);
    check("abort_ready", 32'(op_ready), 32'd1);
    check("abort_no_write", 32'(wen_count), 32'(wen_before));

    // DUP / REPLACE / illegal opcode from depth 1
    do_op(3'd5, 16'h1234);
    check("replace_empty_err", 32'(err), 32'd1);
    do_op(3'd1, 16'h1234);
    do_op(3'd4, 16'h0);
    check("swap_d1_err", 32'(err), 32'd1);
    check("swap_d1_lat", 32'(lat), 32'd1);
    do_op(3'd3, 16'h0);
    check("dup_wen", 32'(acc_wen), 32'd1);
    check("dup_addr", 32'(acc_addr), 32'd0);
    check("dup_wdata", 32'(acc_wdata), 32'h1234);
    check("dup_depth", 32'(depth), 32'd2);
    check("dup_tos", 32'(tos), 32'h1234);
    do_op(3'd5, 16'h5A5A);
    check("replace_wen", 32'(acc_wen), 32'd0);
    check("replace_tos", 32'(tos), 32'h5A5A);
    check("replace_depth", 32'(depth), 32'd2);
    do_op(3'd7, 16'hFFFF);
    check("op7_err", 32'(err), 32'd1);
    check("op7_wen", 32'(acc_wen), 32'd0);
    check("op7_tos", 32'(tos), 32'h5A5A);
    check("op7_depth", 32'(depth), 32'd2);
    check("dup_mem0", 32'(mem[0]), 32'h1234);
    do_op(3'd0, 16'h0);
    check("nop_done", 32'(done), 32'd1);
    check("nop_err", 32'(err), 32'd0);
    check("nop_depth", 32'(depth), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
